neuron_feeder: RTL and testbench
================================

NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, the Q1.15 data, weight and bias width.
REQ-002 SHALL have parameter NUM_INPUTS, default 784, the number of input/weight beats per neuron evaluation.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, the pixel and weight memory address width; the minimum legal value is ceil(log2(NUM_INPUTS)).
REQ-004 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for the neuron result.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to run one neuron evaluation.
REQ-008 pause  in  1  while high, no new memory reads are issued.
REQ-009 bias_cfg  in  IN_WIDTH  bias for this evaluation.
REQ-010 pix_rd_en / w_rd_en  out  1 each  memory read strobes; the two strobes are always equal.
REQ-011 pix_addr / w_addr  out  ADDR_WIDTH each  read addresses; the two addresses are always equal.
REQ-012 pix_data / w_data  in  IN_WIDTH each  memory read data, valid one cycle after the strobe.
REQ-013 n_data_in, n_weight_in, n_bias_in  out  IN_WIDTH each  drive to the downstream neuron.
REQ-014 n_input_valid  out  1  beat-valid to the neuron.
REQ-015 n_data_out  in  IN_WIDTH  neuron result.
REQ-016 n_out_valid  in  1  neuron result valid.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 result  out  IN_WIDTH  captured neuron output.
REQ-019 result_valid  out  1  one-cycle pulse when result is updated.
REQ-020 timeout_err  out  1  sticky error flag; cleared only by rst or by an accepted start.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, DRAIN, WAIT_RES and DONE.
REQ-022 In IDLE, start=1 SHALL latch bias_cfg into bias_q, clear idx to 0, clear timeout_err and move to ISSUE; start SHALL be ignored in every other state.
REQ-023 In ISSUE with pause=0, the block SHALL assert the read strobes combinationally with address idx and increment idx; with pause=1 the strobes SHALL be low and idx SHALL hold.
REQ-024 After the strobe for idx=NUM_INPUTS-1 is issued, the FSM SHALL move to DRAIN for one cycle and then to WAIT_RES.
REQ-025 n_input_valid SHALL be the read strobe delayed by one cycle.
REQ-026 n_data_in and n_weight_in SHALL be driven from pix_data and w_data directly, so data and valid align.
REQ-027 n_bias_in SHALL equal bias_q whenever busy=1.
REQ-028 Each evaluation SHALL deliver exactly NUM_INPUTS beats in ascending address order, with no duplicated or dropped beat across pause edges.
REQ-029 With pause held low, the beats SHALL be back-to-back, and the first n_input_valid SHALL occur 2 cycles after start is sampled.
REQ-030 In WAIT_RES, n_out_valid=1 SHALL capture n_data_out into result, pulse result_valid for one cycle and move to DONE.
REQ-031 If n_out_valid=1 is received outside WAIT_RES, it SHALL be ignored.
REQ-032 If TIMEOUT cycles elapse in WAIT_RES without n_out_valid, the block SHALL set timeout_err, leave result unchanged, not pulse result_valid, and move to DONE.
REQ-033 DONE SHALL last one cycle and then return to IDLE, so a new start is accepted on the following cycle at the earliest.
REQ-034 The cycle counter in WAIT_RES SHALL be sized to hold TIMEOUT and SHALL saturate.
REQ-035 No arithmetic is performed in this block; all data paths SHALL be pass-through or register, with no sign changes.

Reset
REQ-036 rst SHALL force IDLE and set idx=0, strobes=0, n_input_valid=0, busy=0, result=0, result_valid=0, timeout_err=0 and bias_q=0.
REQ-037 rst asserted mid-ISSUE SHALL abort the stream, with no further n_input_valid after the reset edge; the neuron shares rst, so its partial sum is discarded.
REQ-038 rst has priority over start, pause and n_out_valid.

Verification
REQ-039 Directed: start, pause=0, NUM_INPUTS=4, memory data 0x4000 for all beats, bias 0x0000, model neuron -> 4 contiguous beats with addresses 0..3 and result=0x2000.
REQ-040 Directed: pause high for 3 cycles after beat 2 -> exactly 4 beats delivered, addresses 0,1,2,3 in order with a 3-cycle gap, and the result is identical to the unpaused run.
REQ-041 Directed: n_out_valid withheld, TIMEOUT=15 -> timeout_err=1 on the 15th WAIT_RES cycle, result_valid never pulses, and busy drops 2 cycles later.
REQ-042 Directed: start pulsed repeatedly while busy -> one evaluation only and exactly NUM_INPUTS beats.
REQ-043 Directed: rst at beat 2 of 4, then start -> the fresh run starts at address 0 and its result matches a clean run.
REQ-044 Directed: bias_cfg changed while busy -> n_bias_in stays at the value latched at start.

Source files
------------

// File: rtl/neuron_feeder.sv
// Streams NUM_INPUTS pixel/weight pairs plus a latched bias into a downstream neuron,
// then waits a bounded time for the neuron's result and captures it.
module neuron_feeder #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned NUM_INPUTS = 784,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic [IN_WIDTH-1:0]   bias_cfg,
  output logic                  pix_rd_en,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [IN_WIDTH-1:0]   pix_data,
  input  logic [IN_WIDTH-1:0]   w_data,
  output logic [IN_WIDTH-1:0]   n_data_in,
  output logic [IN_WIDTH-1:0]   n_weight_in,
  output logic [IN_WIDTH-1:0]   n_bias_in,
  output logic                  n_input_valid,
  input  logic [IN_WIDTH-1:0]   n_data_out,
  input  logic                  n_out_valid,
  output logic                  busy,
  output logic [IN_WIDTH-1:0]   result,
  output logic                  result_valid,
  output logic                  timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_RES, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CNT_W-1:0]      cnt;
  logic [IN_WIDTH-1:0]   bias_q;
  logic                  rd_en;

  // Strobe is combinational so a pause takes effect in the same cycle it is raised.
  assign rd_en       = (state == ISSUE) && !pause;
  assign pix_rd_en   = rd_en;
  assign w_rd_en     = rd_en;
  assign pix_addr    = idx;
  assign w_addr      = idx;
  assign n_data_in   = pix_data;
  assign n_weight_in = w_data;
  assign n_bias_in   = bias_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      bias_q        <= '0;
      n_input_valid <= 1'b0;
      result        <= '0;
      result_valid  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      n_input_valid <= rd_en;
      result_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bias_q      <= bias_cfg;
            idx         <= '0;
            timeout_err <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!pause) begin
            if (idx == LAST_IDX) state <= DRAIN;
            else                 idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          cnt   <= '0;
          state <= WAIT_RES;
        end
        WAIT_RES: begin
          // A result arriving on the last allowed cycle still wins over the timeout.
          if (n_out_valid) begin
            result       <= n_data_out;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (cnt >= CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed table-driven bench for neuron_feeder with a 4-input neuron whose
// response is the mean of Q1.15 products plus bias.
module tb_neuron_feeder;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [W-1:0]  bias_cfg = '0;
  logic          pix_rd_en, w_rd_en;
  logic [AW-1:0] pix_addr, w_addr;
  logic [W-1:0]  pix_data = '0;
  logic [W-1:0]  w_data = '0;
  logic [W-1:0]  n_data_in, n_weight_in, n_bias_in;
  logic          n_input_valid;
  logic [W-1:0]  n_data_out = '0;
  logic          n_out_valid = 1'b0;
  logic          busy;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          timeout_err;

  neuron_feeder #(.IN_WIDTH(W), .NUM_INPUTS(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .bias_cfg(bias_cfg),
    .pix_rd_en(pix_rd_en), .w_rd_en(w_rd_en), .pix_addr(pix_addr), .w_addr(w_addr),
    .pix_data(pix_data), .w_data(w_data), .n_data_in(n_data_in), .n_weight_in(n_weight_in),
    .n_bias_in(n_bias_in), .n_input_valid(n_input_valid), .n_data_out(n_data_out),
    .n_out_valid(n_out_valid), .busy(busy), .result(result), .result_valid(result_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] pmem [N];
  logic [W-1:0] wmem [N];

  always @(posedge clk) begin
    if (pix_rd_en) pix_data <= pmem[pix_addr];
    if (w_rd_en)   w_data   <= wmem[w_addr];
  end

  // Beat / strobe log, sampled mid-cycle.
  logic [W-1:0]  bdata [512];
  logic [W-1:0]  bw    [512];
  logic [W-1:0]  bbias [512];
  int            bcyc  [512];
  logic [AW-1:0] aaddr [512];
  int nb = 0, na = 0, rv_cnt = 0, cyc = 0, strobe_bad = 0;

  always @(negedge clk) begin
    if (n_input_valid) begin
      bdata[nb] <= n_data_in;
      bw[nb]    <= n_weight_in;
      bbias[nb] <= n_bias_in;
      bcyc[nb]  <= cyc;
      nb        <= nb + 1;
    end
    if (pix_rd_en) begin
      aaddr[na] <= pix_addr;
      na        <= na + 1;
    end
    if (pix_rd_en != w_rd_en || pix_addr != w_addr) strobe_bad <= strobe_bad + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
    cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          pause_beat;
    int          pause_len;
    logic [15:0] bias;
    logic [15:0] bias_chg;
    bit          respond;
    int          resp_lat;
    bit          ramp;
    bit          hammer;
    bit          spur;
    int          exp_first;
    int          exp_span;
    logic [15:0] exp_result;
    bit          exp_to;
    int          exp_rv;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input bit ramp);
    for (int k = 0; k < N; k++) begin
      pmem[k] = 16'h4000;
      wmem[k] = ramp ? 16'(16'h1000 * (k + 1)) : 16'h4000;
    end
  endtask

  task automatic run_eval(input vec_t v, output int t0, output int nb0, output int na0, output int rv0);
    int g, pleft, nbeats;
    bit pdone;
    logic signed [31:0] sum, prod;
    load_mem(v.ramp);
    tick();
    start = 1'b1;
    bias_cfg = v.bias;
    t0 = cyc; nb0 = nb; na0 = na; rv0 = rv_cnt;
    g = 0; pleft = 0; pdone = 1'b0;
    while (nb - nb0 < N && g < 100) begin
      tick();
      g++;
      start = v.hammer ? g[0] : 1'b0;
      bias_cfg = v.bias_chg;
      if (!pdone && v.pause_beat >= 0 && na - na0 == v.pause_beat) begin
        pdone = 1'b1;
        pleft = v.pause_len;
      end
      pause = (pleft > 0);
      if (pleft > 0) pleft--;
      n_out_valid = v.spur && g == 1;
      n_data_out = 16'h5555;
    end
    start = 1'b0;
    pause = 1'b0;
    n_out_valid = 1'b0;
    nbeats = nb - nb0;
    sum = '0;
    for (int k = 0; k < nbeats; k++) begin
      prod = $signed(bdata[nb0+k]) * $signed(bw[nb0+k]);
      sum += prod >>> 15;
    end
    if (nbeats > 0) sum = (sum >>> 2) + 32'($signed(bbias[nb0+nbeats-1]));
    if (v.respond) begin
      repeat (v.resp_lat) tick();
      n_out_valid = 1'b1;
      n_data_out = sum[15:0];
      tick();
      n_out_valid = 1'b0;
    end
    g = 0;
    while (busy && g < 60) begin
      tick();
      g++;
    end
    check("busy_release", 32'(busy), 32'd0);
  endtask

  task automatic check_row(input string tag, input vec_t v, input int t0, input int nb0,
                           input int na0, input int rv0);
    logic [7:0] seq;
    int wbad, bbad;
    seq = '0;
    for (int k = 0; k < N; k++) seq = {seq[5:0], aaddr[na0+k]};
    wbad = 0;
    bbad = 0;
    for (int k = 0; k < N; k++) begin
      if (bw[nb0+k] !== wmem[k]) wbad++;
      if (bbias[nb0+k] !== v.bias) bbad++;
    end
    check({tag, " beats"},   32'(nb - nb0), 32'(N));
    check({tag, " strobes"}, 32'(na - na0), 32'(N));
    check({tag, " addr_seq"}, 32'(seq), 32'h1B);
    check({tag, " first_valid"}, 32'(bcyc[nb0] - t0), 32'(v.exp_first));
    check({tag, " span"}, 32'(bcyc[nb0+N-1] - bcyc[nb0]), 32'(v.exp_span));
    check({tag, " weight_order"}, 32'(wbad), 32'd0);
    check({tag, " bias_hold"}, 32'(bbad), 32'd0);
    check({tag, " result"}, 32'(result), 32'(v.exp_result));
    check({tag, " timeout_err"}, 32'(timeout_err), 32'(v.exp_to));
    check({tag, " result_valid_pulses"}, 32'(rv_cnt - rv0), 32'(v.exp_rv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, nb0, na0, rv0;
    vec_t rst_run;
    vecs[0] = '{-1, 0, 16'h0000, 16'h0000, 1'b1,  0, 1'b0, 1'b0, 1'b0, 2, 3, 16'h2000, 1'b0, 1};
    vecs[1] = '{ 2, 3, 16'h0000, 16'h0000, 1'b1,  2, 1'b0, 1'b0, 1'b1, 2, 6, 16'h2000, 1'b0, 1};
    vecs[2] = '{-1, 0, 16'h0100, 16'h7FFF, 1'b1,  3, 1'b0, 1'b0, 1'b0, 2, 3, 16'h2100, 1'b0, 1};
    vecs[3] = '{-1, 0, 16'hFF00, 16'hFF00, 1'b1,  5, 1'b1, 1'b0, 1'b0, 2, 3, 16'h1300, 1'b0, 1};
    vecs[4] = '{ 0, 2, 16'h0000, 16'h0000, 1'b1,  1, 1'b1, 1'b0, 1'b0, 4, 3, 16'h1400, 1'b0, 1};
    vecs[5] = '{ 3, 1, 16'h0000, 16'h0000, 1'b1,  0, 1'b0, 1'b0, 1'b0, 2, 4, 16'h2000, 1'b0, 1};
    vecs[6] = '{-1, 0, 16'h0000, 16'h0000, 1'b0,  0, 1'b0, 1'b0, 1'b0, 2, 3, 16'h2000, 1'b1, 0};
    vecs[7] = '{-1, 0, 16'h0010, 16'h0000, 1'b1, 14, 1'b1, 1'b0, 1'b0, 2, 3, 16'h1410, 1'b0, 1};
    vecs[8] = '{-1, 0, 16'h0000, 16'h0000, 1'b1,  4, 1'b0, 1'b1, 1'b0, 2, 3, 16'h2000, 1'b0, 1};
    load_mem(1'b0);

    // Reset beats start and a stray neuron result.
    rst = 1'b1; start = 1'b1; bias_cfg = 16'hABCD; n_out_valid = 1'b1; n_data_out = 16'h1234;
    repeat (3) tick();
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst n_input_valid", 32'(n_input_valid), 32'd0);
    check("rst strobe", 32'(pix_rd_en), 32'd0);
    check("rst bias", 32'(n_bias_in), 32'd0);
    tick();
    rst = 1'b0; start = 1'b0; n_out_valid = 1'b0; bias_cfg = '0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_eval(vecs[i], t0, nb0, na0, rv0);
      check_row($sformatf("row%0d", i), vecs[i], t0, nb0, na0, rv0);
    end

    // Exact timeout timing: start in cycle s, 15th WAIT_RES cycle is s+20.
    load_mem(1'b0);
    tick();
    start = 1'b1;
    rv0 = rv_cnt;
    tick();
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("to s+19 err", 32'(timeout_err), 32'd0);
    check("to s+19 busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    check("to s+21 err", 32'(timeout_err), 32'd1);
    check("to s+21 busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to s+22 busy", 32'(busy), 32'd0);
    check("to no pulse", 32'(rv_cnt - rv0), 32'd0);
    check("to result kept", 32'(result), 32'h2000);

    // Reset in the middle of the stream, then a clean run.
    tick();
    start = 1'b1;
    nb0 = nb;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("midrst beats", 32'(nb - nb0), 32'd2);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    rst_run = vecs[0];
    run_eval(rst_run, t0, nb0, na0, rv0);
    check_row("after_rst", rst_run, t0, nb0, na0, rv0);

    // Neuron result while idle must be ignored.
    rv0 = rv_cnt;
    n_out_valid = 1'b1;
    n_data_out = 16'h5555;
    tick();
    n_out_valid = 1'b0;
    repeat (2) tick();
    check("idle nov result", 32'(result), 32'h2000);
    check("idle nov pulse", 32'(rv_cnt - rv0), 32'd0);
    check("idle nov busy", 32'(busy), 32'd0);

    check("strobe_equal", 32'(strobe_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
